// File: rtl/shared_pkg.sv
// rtl/shared_pkg.sv - bus widths, register indices and FSM encoding shared by the APB slave
package shared_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    localparam logic [31:0] APB_SLV_ID = 32'hA9B0_0001;

    localparam int ID_IDX  = 0;
    localparam int CNT_IDX = 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_slv_state_e;

endpackage

// File: rtl/apb_slave_regbank.sv
// rtl/apb_slave_regbank.sv - register storage, byte-strobed write port, XFER_CNT counter and read mux
module apb_slave_regbank #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_we,
    input  logic [$clog2(NUM_REGS)-1:0] i_widx,
    input  logic [DATA_WIDTH-1:0]       i_wdata,
    input  logic [DATA_WIDTH/8-1:0]     i_wstrb,
    input  logic                        i_cnt_inc,
    input  logic [$clog2(NUM_REGS)-1:0] i_ridx,
    output logic [DATA_WIDTH-1:0]       o_rdata
);
    import shared_pkg::*;

    localparam int IW = $clog2(NUM_REGS);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] r_cnt;

    // Slots 0 and 1 are never written: the decoder rejects writes there and the read mux overrides them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_cnt <= '0;
        end else begin
            if (i_we) begin
                for (int b = 0; b < DATA_WIDTH/8; b++) begin
                    if (i_wstrb[b]) begin
                        r_regs[i_widx][b*8 +: 8] <= i_wdata[b*8 +: 8];
                    end
                end
            end
            if (i_cnt_inc) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        o_rdata = r_regs[i_ridx];
        if (i_ridx == IW'(ID_IDX)) begin
            o_rdata = DATA_WIDTH'(APB_SLV_ID);
        end else if (i_ridx == IW'(CNT_IDX)) begin
            o_rdata = r_cnt;
        end
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB completer top: FSM, decode, error checks; wait states under APB_SLV_WAIT_EN
module apb_slave_regfile #(
    parameter int ADDR_WIDTH  = shared_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH  = shared_pkg::DATA_WIDTH,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);
    import shared_pkg::*;

    localparam int IW = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS*4);
`ifdef APB_SLV_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif
    localparam int W = WAIT_EN ? WAIT_CYCLES : 0;

    apb_slv_state_e            r_state;
    apb_slv_state_e            w_state;
    logic                      r_write;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [DATA_WIDTH/8-1:0]   r_strb;
    logic [DATA_WIDTH-1:0]     r_prdata;
    logic                      r_pready;
    logic                      r_pslverr;

    logic                      w_setup;
    logic                      w_write;
    logic [ADDR_WIDTH-1:0]     w_addr;
    logic [DATA_WIDTH/8-1:0]   w_strb;
    logic [IW-1:0]             w_idx;
    logic                      w_err;
    logic                      w_first_ready;
    logic                      w_last_wait;
    logic                      w_present;
    logic                      w_commit;
    logic [DATA_WIDTH-1:0]     w_rdata;

    // The setup phase is recognised straight off the bus so zero-wait completion can be registered at its end.
    assign w_setup = (r_state == IDLE) && PSEL && !PENABLE;
    assign w_state = w_setup ? SETUP : r_state;

    assign w_write = w_setup ? PWRITE : r_write;
    assign w_addr  = w_setup ? PADDR  : r_addr;
    assign w_strb  = w_setup ? PSTRB  : r_strb;
    assign w_idx   = w_addr[2 +: IW];

    assign w_err = (w_addr[1:0] != 2'b00)
                || (w_addr >= ADDR_LIMIT)
                || (w_write && ((w_idx == IW'(ID_IDX)) || (w_idx == IW'(CNT_IDX))))
                || (!w_write && (w_strb != '0));

    assign w_first_ready = (W == 0);

`ifdef APB_SLV_WAIT_EN
    localparam int CW = (W > 1) ? $clog2(W + 1) : 1;
    logic [CW-1:0] r_wait;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_wait <= '0;
        end else if (w_setup) begin
            r_wait <= CW'(W);
        end else if ((r_state == ACCESS) && (r_wait != '0)) begin
            r_wait <= r_wait - 1'b1;
        end
    end

    assign w_last_wait = (r_wait == CW'(1));
`else
    assign w_last_wait = 1'b1;
`endif

    assign w_present = ((w_state == SETUP) && w_first_ready)
                    || ((w_state == ACCESS) && !r_pready && PSEL && PENABLE && w_last_wait);

    // r_pready marks the completion cycle; its closing edge commits the write and bumps XFER_CNT.
    assign w_commit = r_pready && !r_pslverr;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state   <= IDLE;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_strb    <= '0;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
        end else begin
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            case (w_state)
                SETUP: begin
                    r_state <= ACCESS;
                    r_write <= PWRITE;
                    r_addr  <= PADDR;
                    r_wdata <= PWDATA;
                    r_strb  <= PSTRB;
                end
                ACCESS: begin
                    if (r_pready || !PSEL || !PENABLE) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (w_present) begin
                r_pready  <= 1'b1;
                r_pslverr <= w_err;
                r_prdata  <= (w_err || w_write) ? '0 : w_rdata;
            end
        end
    end

    apb_slave_regbank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_regbank (
        .i_clk     (PCLK),
        .i_rst_n   (PRESETn),
        .i_we      (w_commit && r_write),
        .i_widx    (r_addr[2 +: IW]),
        .i_wdata   (r_wdata),
        .i_wstrb   (r_strb),
        .i_cnt_inc (w_commit),
        .i_ridx    (w_idx),
        .o_rdata   (w_rdata)
    );

    assign PRDATA  = r_prdata;
    assign PREADY  = r_pready;
    assign PSLVERR = r_pslverr;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - randomized bench for apb_slave_regfile against a register-map model
module tb_apb_slave_regfile;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 16;
    localparam int WC = 2;
`ifdef APB_SLV_WAIT_EN
    localparam int W = WC;
`else
    localparam int W = 0;
`endif

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [3:0]    PSTRB;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    apb_slave_regfile #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .NUM_REGS    (NR),
        .WAIT_CYCLES (WC)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PSTRB   (PSTRB),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] model [NR];
    logic [31:0] m_cnt;
    logic [31:0] rd;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) model[i] = '0;
        m_cnt = '0;
    endtask

    task automatic bus_idle();
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        check("idle_pready", PREADY, 1'b0);
        check("idle_prdata", PRDATA, 32'h0);
    endtask

    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output logic [31:0] rdata);
        logic        exp_err;
        logic [31:0] exp_rd;
        logic        got_err;
        int          lat;
        int          idx;
        idx     = int'(addr / 4);
        exp_err = (addr % 4 != 0) || (addr >= NR*4) || (wr && idx < 2) || (!wr && strb != 0);
        exp_rd  = '0;
        if (!exp_err && !wr) begin
            if (idx == 0)      exp_rd = 32'hA9B0_0001;
            else if (idx == 1) exp_rd = m_cnt;
            else               exp_rd = model[idx];
        end
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; PSTRB = strb;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        lat = -1; rdata = '0; got_err = 1'b0;
        for (int k = 1; k <= W + 8; k++) begin
            @(negedge PCLK);
            if (PREADY === 1'b1) begin
                lat = k; rdata = PRDATA; got_err = PSLVERR;
                break;
            end
            check("wait_prdata", PRDATA, 32'h0);
        end
        check("latency", lat, W + 1);
        check("pslverr", got_err, exp_err);
        check("prdata", rdata, exp_rd);
        if (!exp_err) begin
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) model[idx][b*8 +: 8] = wdata[b*8 +: 8];
            end
            m_cnt = m_cnt + 1;
        end
    endtask

    initial begin
        logic [31:0] a;
        logic        wr;
        logic [3:0]  st;
        int          r;
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PSTRB = '0;
        model_reset();
        repeat (2) @(negedge PCLK);
        check("rst_pready", PREADY, 1'b0);
        check("rst_prdata", PRDATA, 32'h0);
        check("rst_pslverr", PSLVERR, 1'b0);
        PRESETn = 1'b1;

        xfer(1'b1, 32'h08, 32'hDEAD_BEEF, 4'hF, rd);
        xfer(1'b0, 32'h08, 32'h0, 4'h0, rd);
        check("plan_deadbeef", rd, 32'hDEAD_BEEF);
        xfer(1'b1, 32'h0C, 32'h1122_3344, 4'b0101, rd);
        xfer(1'b0, 32'h0C, 32'h0, 4'h0, rd);
        check("plan_strobe", rd, 32'h0022_0044);
        xfer(1'b0, 32'h00, 32'h0, 4'h0, rd);
        check("plan_id", rd, 32'hA9B0_0001);
        xfer(1'b1, 32'h00, 32'h1234_5678, 4'hF, rd);
        xfer(1'b0, 32'h00, 32'h0, 4'h0, rd);
        check("plan_id_kept", rd, 32'hA9B0_0001);
        xfer(1'b0, 32'h40, 32'h0, 4'h0, rd);
        xfer(1'b0, 32'h06, 32'h0, 4'h0, rd);
        xfer(1'b0, 32'h08, 32'h0, 4'h1, rd);
        xfer(1'b0, 32'h04, 32'h0, 4'h0, rd);
        bus_idle();

        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = 32'($urandom_range(0, NR-1) * 4 + $urandom_range(1, 3));
            else if (r == 1) a = 32'(NR*4 + 4 * $urandom_range(0, 1000));
            else             a = 32'($urandom_range(0, NR-1) * 4);
            wr = 1'($urandom_range(0, 1));
            if (wr) st = 4'($urandom);
            else    st = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            xfer(wr, a, $urandom, st, rd);
            if ($urandom_range(0, 3) == 0) bus_idle();
        end

        xfer(1'b1, 32'h14, 32'h0000_CAFE, 4'hF, rd);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h14; PWDATA = 32'h5555_AAAA; PSTRB = 4'hF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #2 PRESETn = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        check("midrst_pready", PREADY, 1'b0);
        check("midrst_prdata", PRDATA, 32'h0);
        check("midrst_pslverr", PSLVERR, 1'b0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        model_reset();

        xfer(1'b1, 32'h08, 32'h0000_0001, 4'hF, rd);
        xfer(1'b1, 32'h0C, 32'h0000_0002, 4'h3, rd);
        xfer(1'b1, 32'h18, 32'h0000_0003, 4'h0, rd);
        xfer(1'b0, 32'h04, 32'h0, 4'h0, rd);
        check("plan_cnt3", rd, 32'd3);
        xfer(1'b0, 32'h14, 32'h0, 4'h0, rd);
        check("plan_rst_cleared", rd, 32'h0);
        bus_idle();

`ifdef APB_SLV_WAIT_EN
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h10; PWDATA = 32'h5; PSTRB = 4'hF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        check("abort_first", PREADY, 1'b0);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        for (int k = 0; k < W + 2; k++) begin
            @(negedge PCLK);
            check("abort_pready", PREADY, 1'b0);
        end
`endif
        xfer(1'b0, 32'h10, 32'h0, 4'h0, rd);
        check("plan_abort_reg", rd, 32'h0);
        xfer(1'b0, 32'h04, 32'h0, 4'h0, rd);
        bus_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

APB completer holding a small word-addressed register bank. It is the responder end of the bus that the team's APB master drives: it decodes PSEL/PENABLE/PADDR, applies byte-strobed writes, and returns PRDATA/PREADY/PSLVERR. It sits behind the master inside the APB wrapper and is the golden-checked slave for the UVM environment.

## Interface
- ADDR_WIDTH, 32, PADDR width (from shared_pkg)
- DATA_WIDTH, 32, data width; must be a multiple of 8 and at least 32
- NUM_REGS, 16, number of registers; a power of two, at least 4
- WAIT_CYCLES, 2, PREADY-low cycles per access (used only with APB_SLV_WAIT_EN)

Ports:
- PCLK  in  1  bus clock, rising-edge
- PRESETn  in  1  reset, asynchronous, active-low
- PSEL  in  1  slave select
- PENABLE  in  1  access phase
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_WIDTH  byte address
- PWDATA  in  DATA_WIDTH  write data
- PSTRB  in  DATA_WIDTH/8  write byte strobes
- PRDATA  out  DATA_WIDTH  read data; 0 except in a read completion cycle
- PREADY  out  1  completion of the access
- PSLVERR  out  1  error, valid only while PREADY=1

## Operation
- Register map:
  - Index 0 is ID. It is read-only and returns APB_SLV_ID.
  - Index 1 is XFER_CNT. It is read-only, counts OK completions, and wraps from all-ones to 0.
  - Indices 2..NUM_REGS-1 are read/write and reset to 0.
- Address index is PADDR[2 +: $clog2(NUM_REGS)].
- An access is an error if any of these is true:
  - PADDR[1:0] != 0
  - PADDR >= NUM_REGS*4
  - it is a write to index 0 or 1
  - it is a read with PSTRB != 0
- On an error the bank and XFER_CNT are unchanged, PRDATA = 0 and PSLVERR = 1.
- Writes update only the bytes whose PSTRB bit is 1. PSTRB = 0 is a legal no-op write and counts as OK.
- FSM states:
  - IDLE → SETUP on PSEL & !PENABLE. Address, control, data and strobes are latched.
  - SETUP → ACCESS unconditionally. The wait counter is loaded.
  - ACCESS stays while the counter is nonzero. It decrements each cycle and holds PREADY = 0.
  - ACCESS → IDLE at completion. Completion is a single cycle with PREADY = 1.
- Abort: PSEL = 0 or PENABLE = 0 while in ACCESS before completion sends the FSM to IDLE. There is no write, no count, and no PREADY.
- Decode uses the values latched in SETUP. Changes to PADDR, PWDATA or PWRITE during ACCESS are ignored.

## Timing
- Reset values: PRDATA = 0, PREADY = 0, PSLVERR = 0, state IDLE, bank = 0, XFER_CNT = 0.
- Reset asserted mid-transfer aborts the transfer immediately. No write completes.
- All outputs are registered.
- For a setup cycle T, PREADY is high in cycle T+1+W, where W is the number of wait cycles.
- PRDATA and PSLVERR are valid in that same cycle and are 0 in every other cycle.
- The write commit and the XFER_CNT increment happen at the rising edge that ends the completion cycle.
- Back-to-back transfers: a new setup is accepted in the cycle right after completion, giving 2+W cycles per transfer.
- Read-after-write to the same register returns the new value.
- A read of XFER_CNT returns the value before its own completion is counted.

## Configuration
- APB_SLV_WAIT_EN defined: W = WAIT_CYCLES. WAIT_CYCLES = 0 is legal and behaves as zero-wait.
- APB_SLV_WAIT_EN undefined: W = 0. The wait counter is not built and PREADY rises in cycle T+1.

## Structure
- shared_pkg holds:
  - ADDR_WIDTH and DATA_WIDTH
  - APB_SLV_ID = 32'hA9B0_0001
  - the register index constants ID_IDX = 0 and CNT_IDX = 1
  - typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_slv_state_e
- One sub-module, apb_slave_regbank, holds:
  - the storage
  - the strobe-write logic
  - the XFER_CNT counter
  - the read mux
- The top level holds the FSM, address decode, error checks and wait counter.

## Test plan
- Write 0xDEADBEEF to 0x08 with PSTRB = 4'hF, then read 0x08. Expect 0xDEADBEEF with PSLVERR = 0, and PREADY at T+1+W in both transfers.
- Write 0x11223344 to 0x0C with PSTRB = 4'b0101 over a register holding 0. Read returns 0x00220044.
- Read 0x00 returns 0xA9B00001. Write 0x00 gives PSLVERR = 1 and a subsequent read is still 0xA9B00001.
- Read 0x40 (out of range), read 0x06 (misaligned), and read with PSTRB = 4'h1. Each gives PSLVERR = 1, PRDATA = 0, and XFER_CNT unchanged.
- Three back-to-back OK writes, then read 0x04. Expect 3. Each transfer takes 2+W cycles with no idle cycle between.
- Drop PSEL mid-wait, with APB_SLV_WAIT_EN and WAIT_CYCLES = 2, on a write of 0x5 to 0x10. Separately, assert PRESETn low mid-access. In both cases there is no PREADY, the register reads 0, and all outputs are 0 while reset is asserted.
